// File: rtl/packet_sink_local.sv
// packet_sink_local
// Ejection endpoint for one ring node. Packets delivered by the router's local
// output are buffered in a small FIFO and drained once every EJECT_CYCLE
// cycles. Each drained packet goes through a two-stage pipeline: stage 1
// computes its network latency from the embedded injection timestamp and
// checks the destination, and stage 2 folds the result into the node statistics.
//
// Packet layout: {valid[48], timestamp[47:32], src[31:16], dst[15:0]}
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_counter         global free-running cycle counter (latency reference)
//   packet_in           packet from the router local output
//   packet_in_wr_en     write strobe for packet_in
//   packet_in_full      FIFO full; valid writes are refused and counted as drops
//   total_packet_recv   packets drained and accounted
//   total_latency       sum of per-packet latencies
//   min_latency         smallest latency seen (16'hFFFF until the first packet)
//   max_latency         largest latency seen
//   error_cnt           drained packets whose dst is not ROUTER_ID (saturating)
//   drop_cnt            valid writes refused while full (saturating)
//   done                sticky, set once total_packet_recv >= NUM_PACKETS_PER_NODE
module packet_sink_local #(
    parameter int NUM_NODES            = 8,
    parameter int ROUTER_ID            = 0,
    parameter int PACKET_SIZE          = 49,
    parameter int BUFFER_SIZE          = 4,
    parameter int EJECT_CYCLE          = 1,
    parameter int NUM_PACKETS_PER_NODE = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            clk_counter,
    input  logic [PACKET_SIZE-1:0] packet_in,
    input  logic                   packet_in_wr_en,
    output logic                   packet_in_full,
    output logic [63:0]            total_packet_recv,
    output logic [63:0]            total_latency,
    output logic [15:0]            min_latency,
    output logic [15:0]            max_latency,
    output logic [15:0]            error_cnt,
    output logic [15:0]            drop_cnt,
    output logic                   done
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int OCC_W = $clog2(BUFFER_SIZE + 1);
    localparam int TMR_W = (EJECT_CYCLE > 1) ? $clog2(EJECT_CYCLE) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUFFER_SIZE);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(EJECT_CYCLE - 1);
    localparam logic [15:0]      LOCAL_ID  = 16'(ROUTER_ID);
    localparam logic [63:0]      DONE_THRS = 64'(NUM_PACKETS_PER_NODE);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        sat_inc16 = (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Wraps modulo 2^16 so a timestamp taken just before the counter rolls
    // over still yields the correct small latency.
    function automatic logic [15:0] calc_latency(input logic [15:0] now, input logic [15:0] ts);
        calc_latency = now - ts;
    endfunction

    // Only the timestamp and destination are needed after the FIFO, so the
    // entry stores {timestamp, dst}.
    logic [31:0]       mem_q [BUFFER_SIZE];
    logic [31:0]       mem_d [BUFFER_SIZE];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              push, refused, pop;
    logic [31:0]       pop_entry;

    logic              vld_p1_q, vld_p1_d;
    logic [15:0]       lat_p1_q, lat_p1_d;
    logic              mis_p1_q, mis_p1_d;

    logic [63:0]       recv_q, recv_d;
    logic [63:0]       tot_lat_q, tot_lat_d;
    logic [15:0]       min_lat_q, min_lat_d;
    logic [15:0]       max_lat_q, max_lat_d;
    logic [15:0]       err_q, err_d;
    logic [15:0]       drop_q, drop_d;
    logic              done_q, done_d;

    // Source field and ring size are not needed by the sink logic.
    logic              unused_ok;
    assign unused_ok = ^{packet_in[31:16], (NUM_NODES > ROUTER_ID)};

    assign packet_in_full = (occ_q == OCC_FULL);

    always_comb begin
        // ---- stage 0: FIFO push / timed pop ----
        push    = packet_in_wr_en && packet_in[48] && !packet_in_full;
        refused = packet_in_wr_en && packet_in[48] && packet_in_full;
        // Occupancy is the registered value, so an entry written this edge
        // is never visible to the pop decision of the same edge.
        pop     = (timer_q == TMR_LAST) && (occ_q != '0);

        timer_d  = (timer_q == TMR_LAST) ? '0 : timer_q + 1'b1;
        occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {packet_in[47:32], packet_in[15:0]};
        end
        pop_entry = mem_q[rd_ptr_q];

        // ---- stage 1: latency and destination check ----
        vld_p1_d = pop;
        lat_p1_d = calc_latency(clk_counter, pop_entry[31:16]);
        mis_p1_d = (pop_entry[15:0] != LOCAL_ID);

        // ---- stage 2: statistics accumulation ----
        recv_d    = recv_q;
        tot_lat_d = tot_lat_q;
        min_lat_d = min_lat_q;
        max_lat_d = max_lat_q;
        err_d     = err_q;
        if (vld_p1_q) begin
            recv_d    = recv_q + 64'd1;
            tot_lat_d = tot_lat_q + {48'd0, lat_p1_q};
            if (lat_p1_q < min_lat_q) min_lat_d = lat_p1_q;
            if (lat_p1_q > max_lat_q) max_lat_d = lat_p1_q;
            err_d     = sat_inc16(err_q, mis_p1_q);
        end
        drop_d = sat_inc16(drop_q, refused);
        done_d = done_q || (recv_q >= DONE_THRS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            timer_q   <= '0;
            vld_p1_q  <= 1'b0;
            recv_q    <= '0;
            tot_lat_q <= '0;
            min_lat_q <= 16'hFFFF;
            max_lat_q <= '0;
            err_q     <= '0;
            drop_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            timer_q   <= timer_d;
            vld_p1_q  <= vld_p1_d;
            recv_q    <= recv_d;
            tot_lat_q <= tot_lat_d;
            min_lat_q <= min_lat_d;
            max_lat_q <= max_lat_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
        end
    end

    // Payload storage and stage-1 data are qualified by occupancy/vld_p1_q,
    // so they carry no reset.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        lat_p1_q <= lat_p1_d;
        mis_p1_q <= mis_p1_d;
    end

    assign total_packet_recv = recv_q;
    assign total_latency     = tot_lat_q;
    assign min_latency       = min_lat_q;
    assign max_latency       = max_lat_q;
    assign error_cnt         = err_q;
    assign drop_cnt          = drop_q;
    assign done              = done_q;

endmodule

// File: tb/tb_packet_sink_local.sv
module tb_packet_sink_local;

  // Third instance used for randomized checking against the queue model.
  localparam int R_ID  = 2;
  localparam int R_BUF = 2;
  localparam int R_EC  = 3;
  localparam int R_N   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] clk_counter = 16'd0;
  logic [48:0] packet_in = '0;
  logic        wr_en = 1'b0;

  logic a_full, b_full, c_full, a_done, b_done, c_done;
  logic [63:0] a_recv, b_recv, c_recv, a_tot, b_tot, c_tot;
  logic [15:0] a_min, b_min, c_min, a_max, b_max, c_max;
  logic [15:0] a_err, b_err, c_err, a_drop, b_drop, c_drop;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state for instance c.
  logic [31:0] mq[$];
  int          m_timer;
  logic        m_s1v, m_mis, m_done;
  logic [15:0] m_lat, m_min, m_max, m_err, m_drop;
  logic [63:0] m_recv, m_tot;

  always #5 clk = ~clk;

  packet_sink_local #(.ROUTER_ID(0), .BUFFER_SIZE(4), .EJECT_CYCLE(1), .NUM_PACKETS_PER_NODE(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .packet_in(packet_in),
    .packet_in_wr_en(wr_en), .packet_in_full(a_full), .total_packet_recv(a_recv),
    .total_latency(a_tot), .min_latency(a_min), .max_latency(a_max),
    .error_cnt(a_err), .drop_cnt(a_drop), .done(a_done));

  packet_sink_local #(.ROUTER_ID(0), .BUFFER_SIZE(4), .EJECT_CYCLE(16), .NUM_PACKETS_PER_NODE(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .packet_in(packet_in),
    .packet_in_wr_en(wr_en), .packet_in_full(b_full), .total_packet_recv(b_recv),
    .total_latency(b_tot), .min_latency(b_min), .max_latency(b_max),
    .error_cnt(b_err), .drop_cnt(b_drop), .done(b_done));

  packet_sink_local #(.ROUTER_ID(R_ID), .BUFFER_SIZE(R_BUF), .EJECT_CYCLE(R_EC), .NUM_PACKETS_PER_NODE(R_N)) dut_c (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter), .packet_in(packet_in),
    .packet_in_wr_en(wr_en), .packet_in_full(c_full), .total_packet_recv(c_recv),
    .total_latency(c_tot), .min_latency(c_min), .max_latency(c_max),
    .error_cnt(c_err), .drop_cnt(c_drop), .done(c_done));

  function automatic logic [48:0] mk(input logic [15:0] ts, input logic [15:0] src, input logic [15:0] dst);
    mk = {1'b1, ts, src, dst};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_timer = 0;
    m_s1v = 1'b0; m_mis = 1'b0; m_done = 1'b0; m_lat = '0;
    m_min = 16'hFFFF; m_max = '0; m_err = '0; m_drop = '0;
    m_recv = '0; m_tot = '0;
  endtask

  // Applies one clock edge of the sink rules to the model, using the inputs
  // present at that edge.
  task automatic model_edge();
    int   sz;
    logic vw;
    sz = mq.size();
    vw = wr_en && packet_in[48];
    if (m_recv >= 64'(R_N)) m_done = 1'b1;
    if (m_s1v) begin
      m_recv = m_recv + 64'd1;
      m_tot  = m_tot + {48'd0, m_lat};
      if (m_lat < m_min) m_min = m_lat;
      if (m_lat > m_max) m_max = m_lat;
      if (m_mis && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    m_s1v = (m_timer == R_EC - 1) && (sz > 0);
    if (m_s1v) begin
      m_lat = clk_counter - mq[0][31:16];
      m_mis = (mq[0][15:0] != 16'(R_ID));
      void'(mq.pop_front());
    end
    if (vw && sz < R_BUF) mq.push_back({packet_in[47:32], packet_in[15:0]});
    else if (vw && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    m_timer = (m_timer == R_EC - 1) ? 0 : m_timer + 1;
  endtask

  task automatic cycle(input logic wr, input logic [48:0] pkt);
    wr_en = wr;
    packet_in = pkt;
    model_edge();
    @(posedge clk);
    #1;
    clk_counter = clk_counter + 16'd1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (a_recv !== 64'd0) begin n_fail++; $display("FAIL rst_recv got=%0d exp=0", a_recv); end
    n_tests++; if (a_tot !== 64'd0) begin n_fail++; $display("FAIL rst_tot got=%0d exp=0", a_tot); end
    n_tests++; if (a_min !== 16'hFFFF) begin n_fail++; $display("FAIL rst_min got=%h exp=ffff", a_min); end
    n_tests++; if (a_max !== 16'd0) begin n_fail++; $display("FAIL rst_max got=%h exp=0", a_max); end
    n_tests++; if ({a_err, a_drop} !== 32'd0) begin n_fail++; $display("FAIL rst_err_drop got=%h exp=0", {a_err, a_drop}); end
    n_tests++; if ({a_full, a_done} !== 2'b00) begin n_fail++; $display("FAIL rst_full_done got=%b exp=00", {a_full, a_done}); end
    n_tests++; if (c_min !== 16'hFFFF) begin n_fail++; $display("FAIL rst_c_min got=%h exp=ffff", c_min); end
  endtask

  task automatic test_single();
    do_reset();
    clk_counter = 16'd20;
    cycle(1'b1, mk(16'd12, 16'd7, 16'd0));
    cycle(1'b0, '0);
    n_tests++; if (a_recv !== 64'd0) begin n_fail++; $display("FAIL single_early_recv got=%0d exp=0", a_recv); end
    cycle(1'b0, '0);
    n_tests++; if (a_recv !== 64'd1) begin n_fail++; $display("FAIL single_recv got=%0d exp=1", a_recv); end
    n_tests++; if (a_tot !== 64'd9) begin n_fail++; $display("FAIL single_tot got=%0d exp=9", a_tot); end
    n_tests++; if ({a_min, a_max} !== {16'd9, 16'd9}) begin n_fail++; $display("FAIL single_minmax got=%0d/%0d exp=9/9", a_min, a_max); end
    n_tests++; if (a_err !== 16'd0) begin n_fail++; $display("FAIL single_err got=%0d exp=0", a_err); end
  endtask

  task automatic test_wrap();
    do_reset();
    clk_counter = 16'd2;
    cycle(1'b1, mk(16'hFFFE, 16'd1, 16'd0));
    idle(3);
    n_tests++; if (a_tot !== 64'd5) begin n_fail++; $display("FAIL wrap_tot got=%0d exp=5", a_tot); end
    n_tests++; if ({a_min, a_max} !== {16'd5, 16'd5}) begin n_fail++; $display("FAIL wrap_minmax got=%0d/%0d exp=5/5", a_min, a_max); end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, mk(clk_counter, 16'd3, 16'd0));
      if (i == 3) begin
        n_tests++; if (b_full !== 1'b0) begin n_fail++; $display("FAIL full_at3 got=%b exp=0", b_full); end
      end
      if (i == 4) begin
        n_tests++; if (b_full !== 1'b1) begin n_fail++; $display("FAIL full_at4 got=%b exp=1", b_full); end
      end
    end
    n_tests++; if (b_drop !== 16'd2) begin n_fail++; $display("FAIL drop_cnt got=%0d exp=2", b_drop); end
    idle(9);
    n_tests++; if (b_full !== 1'b1) begin n_fail++; $display("FAIL full_before_pop got=%b exp=1", b_full); end
    idle(1);
    n_tests++; if (b_full !== 1'b0) begin n_fail++; $display("FAIL full_after_pop got=%b exp=0", b_full); end
    idle(1);
    n_tests++; if (b_recv !== 64'd1) begin n_fail++; $display("FAIL slow_recv got=%0d exp=1", b_recv); end
    n_tests++; if (b_min !== 16'd15) begin n_fail++; $display("FAIL slow_lat got=%0d exp=15", b_min); end
  endtask

  task automatic test_misroute();
    logic [48:0] p;
    do_reset();
    cycle(1'b1, mk(clk_counter, 16'd5, 16'd3));
    p = mk(clk_counter, 16'd5, 16'd0);
    p[48] = 1'b0;
    cycle(1'b1, p);
    idle(4);
    n_tests++; if (a_err !== 16'd1) begin n_fail++; $display("FAIL mis_err got=%0d exp=1", a_err); end
    n_tests++; if (a_recv !== 64'd1) begin n_fail++; $display("FAIL mis_recv got=%0d exp=1", a_recv); end
    n_tests++; if (a_drop !== 16'd0) begin n_fail++; $display("FAIL mis_drop got=%0d exp=0", a_drop); end
  endtask

  task automatic test_completion();
    int budget;
    do_reset();
    for (int l = 1; l <= 20; l++)
      cycle(1'b1, mk(clk_counter + 16'd1 - 16'(l), 16'd4, 16'd0));
    budget = 0;
    while (a_recv < 64'd20 && budget < 10) begin
      idle(1);
      budget++;
    end
    n_tests++; if (a_recv !== 64'd20) begin n_fail++; $display("FAIL done_wait recv got=%0d exp=20", a_recv); end
    n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL done_early got=%b exp=0", a_done); end
    idle(1);
    n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL done_set got=%b exp=1", a_done); end
    n_tests++; if (a_tot !== 64'd210) begin n_fail++; $display("FAIL cmp_tot got=%0d exp=210", a_tot); end
    n_tests++; if ({a_min, a_max} !== {16'd1, 16'd20}) begin n_fail++; $display("FAIL cmp_minmax got=%0d/%0d exp=1/20", a_min, a_max); end
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(clk_counter + 16'd1 - 16'd30, 16'd4, 16'd0));
    idle(4);
    n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got=%b exp=1", a_done); end
    n_tests++; if (a_recv !== 64'd23 || a_max !== 16'd30) begin n_fail++; $display("FAIL cmp_more got=%0d/%0d exp=23/30", a_recv, a_max); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(clk_counter, 16'd6, 16'd0));
    idle(1);
    do_reset();
    n_tests++; if ({b_recv, b_tot} !== 128'd0) begin n_fail++; $display("FAIL mid_b_tot got=%0d/%0d exp=0/0", b_recv, b_tot); end
    n_tests++; if ({b_min, b_max} !== {16'hFFFF, 16'd0}) begin n_fail++; $display("FAIL mid_b_minmax got=%h/%h exp=ffff/0", b_min, b_max); end
    n_tests++; if ({b_full, b_done, b_drop} !== 18'd0) begin n_fail++; $display("FAIL mid_b_ctrl got=%b/%b/%0d exp=0/0/0", b_full, b_done, b_drop); end
    n_tests++; if ({a_recv, a_min} !== {64'd0, 16'hFFFF}) begin n_fail++; $display("FAIL mid_a got=%0d/%h exp=0/ffff", a_recv, a_min); end
    idle(40);
    n_tests++; if (b_recv !== 64'd0 || b_tot !== 64'd0) begin n_fail++; $display("FAIL mid_after got=%0d/%0d exp=0/0", b_recv, b_tot); end
  endtask

  task automatic test_random();
    logic        w;
    logic [48:0] p;
    logic [15:0] dst;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      w   = ($urandom_range(0, 9) < 7);
      dst = ($urandom_range(0, 1) == 0) ? 16'(R_ID) : 16'($urandom_range(0, 7));
      p   = mk(clk_counter - 16'($urandom_range(0, 300)), 16'($urandom), dst);
      if ($urandom_range(0, 9) == 0) p[48] = 1'b0;
      cycle(w, p);
      n_tests++; if (c_recv !== m_recv) begin n_fail++; $display("FAIL rnd_recv cyc=%0d got=%0d exp=%0d", cyc, c_recv, m_recv); end
      n_tests++; if (c_tot !== m_tot) begin n_fail++; $display("FAIL rnd_tot cyc=%0d got=%0d exp=%0d", cyc, c_tot, m_tot); end
      n_tests++; if (c_min !== m_min) begin n_fail++; $display("FAIL rnd_min cyc=%0d got=%0d exp=%0d", cyc, c_min, m_min); end
      n_tests++; if (c_max !== m_max) begin n_fail++; $display("FAIL rnd_max cyc=%0d got=%0d exp=%0d", cyc, c_max, m_max); end
      n_tests++; if (c_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%0d exp=%0d", cyc, c_err, m_err); end
      n_tests++; if (c_drop !== m_drop) begin n_fail++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", cyc, c_drop, m_drop); end
      n_tests++; if (c_full !== (mq.size() == R_BUF)) begin n_fail++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, c_full, (mq.size() == R_BUF)); end
      n_tests++; if (c_done !== m_done) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, c_done, m_done); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_wrap();
    test_full_drop();
    test_misroute();
    test_completion();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
